// File: rtl/morra_sequenziatore_if.sv
// Player-side move handshake for the Morra match sequencer.
// master = player side (drives moves), slave = sequencer side (drives ready).
interface morra_sequenziatore_if;
   logic       p1_valid;
   logic [1:0] p1_move;
   logic       p1_ready;
   logic       p2_valid;
   logic [1:0] p2_move;
   logic       p2_ready;

   modport master (
      output p1_valid, p1_move, p2_valid, p2_move,
      input  p1_ready, p2_ready
   );

   modport slave (
      input  p1_valid, p1_move, p2_valid, p2_move,
      output p1_ready, p2_ready
   );
endinterface

// File: rtl/morra_sequenziatore.sv
// Match sequencer in front of the Morra Cinese core: loads the round limit, collects moves, reports results.
// Optional move timeout is compiled in with `define SEQ_TIMEOUT_EN.
module morra_sequenziatore #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] cfg_manche,
   morra_sequenziatore_if.slave plr,
   output logic       core_inizio,
   output logic [1:0] core_primo,
   output logic [1:0] core_secondo,
   input  logic [1:0] core_manche,
   input  logic [1:0] core_partita,
   output logic       busy,
   output logic       round_done,
   output logic [1:0] round_result,
   output logic [4:0] round_count,
   output logic       match_done,
   output logic [1:0] match_winner,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_COLLECT, S_ISSUE, S_WAIT_RES, S_DONE
   } state_t;

   state_t     state;
   logic [4:0] limit;
   logic [1:0] mv1, mv2;
   logic       cap1, cap2;

   logic       take1, take2, got1, got2;
   logic [1:0] new1, new2;
   logic [4:0] cnt_next;

   // A move counts as captured this cycle if it was already held or transfers now.
   assign take1    = plr.p1_valid & plr.p1_ready;
   assign take2    = plr.p2_valid & plr.p2_ready;
   assign got1     = cap1 | take1;
   assign got2     = cap2 | take2;
   assign new1     = take1 ? plr.p1_move : mv1;
   assign new2     = take2 ? plr.p2_move : mv2;
   assign cnt_next = (core_manche != 2'b00 && round_count != 5'd31) ? round_count + 5'd1
                                                                     : round_count;

`ifdef SEQ_TIMEOUT_EN
   logic [7:0] timer;
   logic       expire;
   assign expire = (timer == 8'(TIMEOUT_CYC - 1));
`endif

   // NOTE: every register here, state and outputs alike, uses non-blocking assignment so all
   // decisions in a cycle see the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         limit        <= '0;
         mv1          <= '0;
         mv2          <= '0;
         cap1         <= 1'b0;
         cap2         <= 1'b0;
         plr.p1_ready <= 1'b0;
         plr.p2_ready <= 1'b0;
         core_inizio  <= 1'b0;
         core_primo   <= '0;
         core_secondo <= '0;
         busy         <= 1'b0;
         round_done   <= 1'b0;
         round_result <= '0;
         round_count  <= '0;
         match_done   <= 1'b0;
         match_winner <= '0;
         timeout_err  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         timer        <= '0;
`endif
      end else begin
         round_done  <= 1'b0;
         match_done  <= 1'b0;
         timeout_err <= 1'b0;
         if (start) begin
            // Start from any state (re)launches a match; an aborted match reports nothing.
            state        <= S_SETUP;
            busy         <= 1'b1;
            core_inizio  <= 1'b1;
            core_primo   <= cfg_manche[1:0];
            core_secondo <= cfg_manche[3:2];
            limit        <= 5'(cfg_manche) + 5'd4;
            round_count  <= '0;
            match_winner <= '0;
            cap1         <= 1'b0;
            cap2         <= 1'b0;
            mv1          <= '0;
            mv2          <= '0;
            plr.p1_ready <= 1'b0;
            plr.p2_ready <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timer        <= '0;
`endif
         end else begin
            case (state)
               S_IDLE: ;
               S_SETUP: begin
                  state        <= S_COLLECT;
                  core_inizio  <= 1'b0;
                  core_primo   <= '0;
                  core_secondo <= '0;
                  plr.p1_ready <= 1'b1;
                  plr.p2_ready <= 1'b1;
               end
               S_COLLECT: begin
                  if (take1) begin
                     cap1         <= 1'b1;
                     mv1          <= plr.p1_move;
                     plr.p1_ready <= 1'b0;
                  end
                  if (take2) begin
                     cap2         <= 1'b1;
                     mv2          <= plr.p2_move;
                     plr.p2_ready <= 1'b0;
                  end
`ifdef SEQ_TIMEOUT_EN
                  timer <= timer + 8'd1;
`endif
                  if (got1 && got2) begin
                     state        <= S_ISSUE;
                     core_primo   <= new1;
                     core_secondo <= new2;
                  end
`ifdef SEQ_TIMEOUT_EN
                  else if (expire) begin
                     // Missing moves are forfeited as 00 so the core annuls the round.
                     state        <= S_ISSUE;
                     timeout_err  <= 1'b1;
                     plr.p1_ready <= 1'b0;
                     plr.p2_ready <= 1'b0;
                     core_primo   <= got1 ? new1 : 2'b00;
                     core_secondo <= got2 ? new2 : 2'b00;
                  end
`endif
               end
               S_ISSUE: state <= S_WAIT_RES;
               S_WAIT_RES: begin
                  round_done   <= 1'b1;
                  round_result <= core_manche;
                  round_count  <= cnt_next;
                  core_primo   <= '0;
                  core_secondo <= '0;
                  cap1         <= 1'b0;
                  cap2         <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                  timer        <= '0;
`endif
                  if (core_partita != 2'b00) begin
                     match_winner <= core_partita;
                     match_done   <= 1'b1;
                     state        <= S_DONE;
                  end else if (cnt_next == limit) begin
                     // Safety stop when the core never declares the match over.
                     match_winner <= 2'b11;
                     match_done   <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     plr.p1_ready <= 1'b1;
                     plr.p2_ready <= 1'b1;
                     state        <= S_COLLECT;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_morra_sequenziatore.sv
// Self-checking bench for morra_sequenziatore with a behavioural Morra core stub and match model.
module tb_morra_sequenziatore;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] cfg_manche;
   logic       core_inizio;
   logic [1:0] core_primo, core_secondo;
   logic [1:0] core_manche, core_partita;
   logic       busy, round_done, match_done, timeout_err;
   logic [1:0] round_result, match_winner;
   logic [4:0] round_count;

   morra_sequenziatore_if plr();

   morra_sequenziatore #(.TIMEOUT_CYC(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_manche   (cfg_manche),
      .plr          (plr),
      .core_inizio  (core_inizio),
      .core_primo   (core_primo),
      .core_secondo (core_secondo),
      .core_manche  (core_manche),
      .core_partita (core_partita),
      .busy         (busy),
      .round_done   (round_done),
      .round_result (round_result),
      .round_count  (round_count),
      .match_done   (match_done),
      .match_winner (match_winner),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // Rock(01) beats scissors(11), paper(10) beats rock, scissors beats paper; a 00 move annuls.
   function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'b00 || b == 2'b00) return 2'b00;
      if (a == b) return 2'b11;
      if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10))
         return 2'b01;
      return 2'b10;
   endfunction

   // Core stub: first player to 3 wins ends the match when end_en is set, otherwise never ends.
   bit end_en;
   int sw1, sw2;
   always_comb begin
      core_manche  = rps(core_primo, core_secondo);
      core_partita = 2'b00;
      if (end_en) begin
         if (sw1 + int'(core_manche == 2'b01) >= 3)      core_partita = 2'b01;
         else if (sw2 + int'(core_manche == 2'b10) >= 3) core_partita = 2'b10;
      end
   end
   always @(posedge clk) begin
      if (core_inizio) begin
         sw1 <= 0;
         sw2 <= 0;
      end else if (round_done) begin
         if (round_result == 2'b01) sw1 <= sw1 + 1;
         if (round_result == 2'b10) sw2 <= sw2 + 1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Match model
   int         m_cnt, m_w1, m_w2, m_limit;
   logic [1:0] m_result;

   task automatic start_match(input logic [3:0] cfg, input bit en);
      end_en     = en;
      m_cnt      = 0;
      m_w1       = 0;
      m_w2       = 0;
      m_limit    = int'(cfg) + 4;
      start      = 1'b1;
      cfg_manche = cfg;
      tick();
      start = 1'b0;
      check("setup_inizio", core_inizio, 1);
      check("setup_primo", core_primo, cfg[1:0]);
      check("setup_secondo", core_secondo, cfg[3:2]);
      check("setup_busy", busy, 1);
      check("setup_count", round_count, 0);
      check("setup_winner", match_winner, 0);
      check("setup_pulses", {round_done, match_done, timeout_err}, 0);
      tick();
      check("collect_inizio", core_inizio, 0);
      check("collect_core", {core_primo, core_secondo}, 0);
   endtask

   // Player N raises valid from COLLECT cycle dN on; 255 means never. Ends in ISSUE.
   task automatic collect(input logic [1:0] m1, input logic [1:0] m2, input int d1, input int d2,
                          output logic [1:0] f1, output logic [1:0] f2);
      bit c1 = 0, c2 = 0, t1, t2, to_hit, done = 0;
      int c = 0;
      while (!done) begin
         check("p1_ready", plr.p1_ready, !c1);
         check("p2_ready", plr.p2_ready, !c2);
         plr.p1_valid = (c >= d1);
         plr.p1_move  = c1 ? 2'($urandom) : m1;
         plr.p2_valid = (c >= d2);
         plr.p2_move  = c2 ? 2'($urandom) : m2;
         t1 = c1 || (c >= d1);
         t2 = c2 || (c >= d2);
         to_hit = 1'b0;
`ifdef SEQ_TIMEOUT_EN
         to_hit = (c == TO - 1) && !(t1 && t2);
`endif
         tick();
         c++;
         c1 = t1;
         c2 = t2;
         check("timeout_err", timeout_err, to_hit);
         if ((c1 && c2) || to_hit) done = 1;
         else if (c > 50) begin
            check("collect_bound", {c1, c2}, 2'b11);
            done = 1;
         end
      end
      plr.p1_valid = 1'b0;
      plr.p2_valid = 1'b0;
      f1 = c1 ? m1 : 2'b00;
      f2 = c2 ? m2 : 2'b00;
      check("issue_ready", {plr.p1_ready, plr.p2_ready}, 0);
      check("issue_primo", core_primo, f1);
      check("issue_secondo", core_secondo, f2);
      check("issue_inizio", core_inizio, 0);
      check("issue_round_done", round_done, 0);
   endtask

   // Starts in ISSUE; ends in COLLECT (match continues) or IDLE (match over).
   task automatic finish_round(input logic [1:0] f1, input logic [1:0] f2, output bit over);
      logic [1:0] win;
      tick();
      check("wait_primo", core_primo, f1);
      check("wait_secondo", core_secondo, f2);
      check("wait_round_done", round_done, 0);
      check("wait_timeout", timeout_err, 0);
      m_result = rps(f1, f2);
      if (m_result != 2'b00 && m_cnt < 31) m_cnt++;
      if (m_result == 2'b01) m_w1++;
      if (m_result == 2'b10) m_w2++;
      if (end_en && m_w1 >= 3)      win = 2'b01;
      else if (end_en && m_w2 >= 3) win = 2'b10;
      else if (m_cnt == m_limit)    win = 2'b11;
      else                          win = 2'b00;
      over = (win != 2'b00);
      tick();
      check("round_done", round_done, 1);
      check("round_result", round_result, m_result);
      check("round_count", round_count, m_cnt);
      check("match_done", match_done, over);
      check("match_winner", match_winner, win);
      check("busy_round", busy, 1);
      if (over) begin
         tick();
         check("idle_busy", busy, 0);
         check("idle_pulses", {round_done, match_done}, 0);
         check("idle_winner_held", match_winner, win);
         check("idle_result_held", round_result, m_result);
         check("idle_core", {core_inizio, core_primo, core_secondo}, 0);
      end
   endtask

   function automatic logic [19:0] all_out();
      return {busy, round_done, round_result, round_count, match_done, match_winner, timeout_err,
              core_inizio, core_primo, core_secondo, plr.p1_ready, plr.p2_ready};
   endfunction

   initial begin
      logic [1:0] f1, f2, a, b;
      bit over;
      int r;
      rst          = 1'b1;
      start        = 1'b0;
      cfg_manche   = '0;
      end_en       = 1'b0;
      plr.p1_valid = 1'b0;
      plr.p1_move  = '0;
      plr.p2_valid = 1'b0;
      plr.p2_move  = '0;
      tick();
      check("reset_outputs", all_out(), 0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_after_reset", all_out(), 0);

      // Reset in the middle of COLLECT with player 1 captured
      start_match(4'd5, 1'b1);
      plr.p1_valid = 1'b1;
      plr.p1_move  = 2'b10;
      tick();
      plr.p1_valid = 1'b0;
      check("mid_p1_ready", plr.p1_ready, 0);
      check("mid_p2_ready", plr.p2_ready, 1);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", all_out(), 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_reset_idle", all_out(), 0);
      start_match(4'd0, 1'b1);

      // P1 wins every round; round 2 has p1 valid held 3 cycles before p2
      over = 0;
      r    = 0;
      while (!over && r < 10) begin
         collect(2'b01, 2'b11, 0, (r == 1) ? 3 : 0, f1, f2);
         finish_round(f1, f2, over);
         r++;
      end
      check("p1_match_rounds", r, 3);

      // Core never ends the match: safety stop after 4 non-annulled rounds
      start_match(4'd0, 1'b0);
      collect(2'b01, 2'b11, 0, 0, f1, f2); finish_round(f1, f2, over);
      collect(2'b10, 2'b10, 1, 0, f1, f2); finish_round(f1, f2, over);
      collect(2'b00, 2'b01, 0, 2, f1, f2); finish_round(f1, f2, over);
      collect(2'b11, 2'b01, 0, 0, f1, f2); finish_round(f1, f2, over);
      collect(2'b10, 2'b01, 2, 1, f1, f2); finish_round(f1, f2, over);
      check("safety_stop_over", over, 1);

      // Abort with start during WAIT_RES
      start_match(4'd2, 1'b1);
      collect(2'b01, 2'b10, 0, 0, f1, f2); finish_round(f1, f2, over);
      collect(2'b11, 2'b11, 0, 0, f1, f2);
      tick();
      start      = 1'b1;
      cfg_manche = 4'd1;
      tick();
      start = 1'b0;
      check("abort_setup_inizio", core_inizio, 1);
      check("abort_count", round_count, 0);
      check("abort_pulses", {round_done, match_done}, 0);
      check("abort_winner", match_winner, 0);
      m_cnt = 0; m_w1 = 0; m_w2 = 0; m_limit = 5;
      tick();
      check("abort_collect_inizio", core_inizio, 0);
      check("abort_no_match_done", match_done, 0);
      collect(2'b11, 2'b10, 0, 0, f1, f2); finish_round(f1, f2, over);

`ifdef SEQ_TIMEOUT_EN
      // Only player 2 sends; player 1 is forfeited as 00
      start_match(4'd0, 1'b1);
      collect(2'b01, 2'b10, 255, 0, f1, f2);
      finish_round(f1, f2, over);
      check("timeout_count_kept", round_count, 0);
      collect(2'b10, 2'b01, 0, 0, f1, f2);
      finish_round(f1, f2, over);
`endif

      // Randomized matches
      for (int k = 0; k < 4; k++) begin
         start_match(4'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
         over = 0;
         r    = 0;
         while (!over && r < 60) begin
            a = 2'($urandom);
            b = 2'($urandom);
            collect(a, b, $urandom_range(0, 3), $urandom_range(0, 3), f1, f2);
            finish_round(f1, f2, over);
            r++;
         end
         check("random_match_ended", over, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/morra_sequenziatore.md
Name: morra_sequenziatore

Overview:
- Match sequencer in front of the Morra Cinese game core.
- Starts a match by loading the core's round limit.
- Collects one move per player per round via valid/ready handshakes, with an optional timeout, then presents both moves to the core.
- Samples the core's round and match results, counts rounds, and reports the round results and the match end.

Parameters:
- TIMEOUT_CYC, 16: COLLECT cycles allowed before missing moves are forfeited; range 2..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin new match, sampled when high
- cfg_manche  in  4  round-limit config; core maximum = cfg_manche+4 (4..19)
- p1_valid  in  1  player 1 move valid
- p1_move  in  2  player 1 move; 00 = no move, 01/10/11 = rock/paper/scissors encoding of core
- p1_ready  out  1  sequencer accepts player 1 move
- p2_valid  in  1  player 2 move valid
- p2_move  in  2  player 2 move
- p2_ready  out  1  sequencer accepts player 2 move
- core_inizio  out  1  core INIZIO
- core_primo  out  2  core PRIMO
- core_secondo  out  2  core SECONDO
- core_manche  in  2  core MANCHE: 00 annulled, 01 P1, 10 P2, 11 draw
- core_partita  in  2  core PARTITA: 00 ongoing, 01 P1, 10 P2, 11 draw
- busy  out  1  high in every state except IDLE
- round_done  out  1  one-cycle pulse, round result valid
- round_result  out  2  last core_manche, held until next round_done
- round_count  out  5  non-annulled rounds this match, saturating at 31
- match_done  out  1  one-cycle pulse at match end
- match_winner  out  2  final result, held until next start
- timeout_err  out  1  one-cycle pulse when a move was forfeited

Behaviour:
- Reset (asynchronous, any state): state IDLE; every output 0; internal captures, timer and limit cleared.
- All outputs are registered.
- States: IDLE, SETUP, COLLECT, ISSUE, WAIT_RES, DONE.
- IDLE:
  - Core ports driven 0.
  - start=1 -> SETUP.
- SETUP (1 cycle):
  - core_inizio=1, core_primo=cfg_manche[1:0], core_secondo=cfg_manche[3:2].
  - Latch limit=cfg_manche+4 (5-bit).
  - Clear round_count, match_winner, captures and timer.
  - -> COLLECT.
- COLLECT:
  - core_inizio=0; core_primo/core_secondo=00.
  - pN_ready=1 while player N is not yet captured.
  - Transfer occurs on pN_valid & pN_ready; the move is stored and pN_ready drops the next cycle.
  - Players are independent; simultaneous valid on both captures both in the same cycle.
  - valid while ready=0 is ignored.
  - Move 00 is accepted and passed through; the core annuls the round.
  - Timer increments every COLLECT cycle.
  - Both captured -> ISSUE.
- ISSUE (1 cycle):
  - core_primo/core_secondo = captured moves; core_inizio=0.
  - -> WAIT_RES.
- WAIT_RES (1 cycle):
  - Moves still driven on the core ports.
  - round_result <= core_manche; round_done=1.
  - If core_manche != 00, round_count increments (saturating).
  - If core_partita != 00: match_winner <= core_partita, -> DONE.
  - Else if the updated round_count == limit: match_winner <= 11, -> DONE. This safety stop applies if the core never ends the match.
  - Else -> COLLECT, with captures and timer cleared.
- DONE (1 cycle):
  - match_done=1 -> IDLE.
  - match_winner and round_result held.
- start=1 in any non-IDLE state aborts the match -> SETUP.
  - No round_done or match_done is generated for the aborted match.
- Reset mid-round discards all captures; no pulse is generated.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined: when timer reaches TIMEOUT_CYC-1 in COLLECT with a move missing:
  - Each missing move is forced to 00.
  - timeout_err pulses 1 cycle.
  - -> ISSUE on the next cycle.
  - The round then resolves as annulled unless the core decides otherwise.
- Undefined: no timer logic; COLLECT waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset during COLLECT with p1 captured -> all outputs 0, state IDLE; next start yields a fresh SETUP with core_inizio=1 for exactly 1 cycle.
- start, cfg_manche=4'b0000:
  - Rounds are P1 wins: p1=01, p2=11, repeated until core_partita=01.
  - Required: round_done each round, round_result=01, round_count increments.
  - match_done pulses once with match_winner=01; busy falls the cycle after DONE.
- Same-cycle valid on both players -> both ready drop together; ISSUE follows next cycle with core_primo/core_secondo equal to the captured moves.
- p1_valid held 3 cycles before p2_valid -> p1 captured once, p1_ready=0 afterwards, later p1_move changes ignored.
- SEQ_TIMEOUT_EN, TIMEOUT_CYC=4, only p2 sends 10:
  - timeout_err pulses on COLLECT cycle 4; core_primo=00 in ISSUE.
  - round_result=00; round_count unchanged.
- Core stub holding core_partita=00, cfg_manche=0:
  - After the 4th non-annulled round, match_winner=11 and match_done pulses.
- start asserted in WAIT_RES -> next state SETUP, round_count=0, no match_done.
